// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types, constants and helpers for the alarm clock controller
// Contents: mode_t (time-keeping mode), buzz_t (buzzer state), field widths,
// NM (minutes per hour) and wrap_next (modulo increment used by the alarm registers).
package clock_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } buzz_t;

    localparam int NM    = 60;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int DAY_W = 3;

    // Next value of a field that wraps from m-1 back to 0.
    function automatic int wrap_next(int v, int m);
        return (v + 1 >= m) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/alarm_buzz_fsm.sv
// rtl/alarm_buzz_fsm.sv - buzzer state machine with shared ring/snooze down-counter
// Optional feature: SNOOZE_EN adds the SNOOZE state; without it the snooze input is ignored.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   match        current time equals the alarm time (only asserted in RUN)
//   alarm_on     alarm enable; low forces IDLE
//   snooze       snooze request while ringing
//   in_run       mode is RUN; low forces IDLE
//   buzz         registered buzzer drive, high only in RING
module alarm_buzz_fsm
    import clock_pkg::*;
#(
    parameter int RING_SEC = 60,
    parameter int SNZ_SEC  = 300
) (
    input  logic clk,
    input  logic reset,
    input  logic match,
    input  logic alarm_on,
    input  logic snooze,
    input  logic in_run,
    output logic buzz
);

    localparam int CMAX = (RING_SEC > SNZ_SEC) ? RING_SEC : SNZ_SEC;
    localparam int CW   = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;

    buzz_t         state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!alarm_on || !in_run) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        state_d = RING;
                        cnt_d   = CW'(RING_SEC - 1);
                    end
                end
                RING: begin
`ifdef SNOOZE_EN
                    if (snooze) begin
                        state_d = SNOOZE;
                        cnt_d   = CW'(SNZ_SEC - 1);
                    end else
`endif
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
`ifdef SNOOZE_EN
                SNOOZE: begin
                    if (cnt_q == '0) begin
                        state_d = RING;
                        cnt_d   = CW'(RING_SEC - 1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

`ifndef SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    assign buzz = (state_q == RING);

endmodule

// File: rtl/alarm_set_ctrl.sv
// rtl/alarm_set_ctrl.sv - mode sequencer, time-counter increment enables, alarm registers and buzzer
// Optional feature: SNOOZE_EN (passed through to alarm_buzz_fsm) enables the snooze behaviour.
// Ports:
//   Pulse, Reset                      clock (one cycle per second in RUN), sync active-high reset
//   Timeset, Alarmset                 level requests for the set modes
//   Minadv, Hrsadv, Dayadv            per-cycle advance buttons
//   Alarmon, Snooze                   alarm enable, snooze request
//   cur_sec/min/hrs/day               current time from the external counters
//   t_sec/min/hrs/day_inc             combinational increment enables for those counters
//   al_min/hrs/day                    alarm time registers
//   disp_sel                          1 while setting the alarm
//   Buzz                              registered buzzer drive
module alarm_set_ctrl
    import clock_pkg::*;
#(
    parameter int NS       = 60,
    parameter int NH       = 24,
    parameter int ND       = 7,
    parameter int RING_SEC = 60,
    parameter int SNZ_SEC  = 300
) (
    input  logic                   Pulse,
    input  logic                   Reset,
    input  logic                   Timeset,
    input  logic                   Alarmset,
    input  logic                   Minadv,
    input  logic                   Hrsadv,
    input  logic                   Dayadv,
    input  logic                   Alarmon,
    input  logic                   Snooze,
    input  logic [SEC_W-1:0]       cur_sec,
    input  logic [MIN_W-1:0]       cur_min,
    input  logic [$clog2(NH)-1:0]  cur_hrs,
    input  logic [DAY_W-1:0]       cur_day,
    output logic                   t_sec_inc,
    output logic                   t_min_inc,
    output logic                   t_hrs_inc,
    output logic                   t_day_inc,
    output logic [MIN_W-1:0]       al_min,
    output logic [$clog2(NH)-1:0]  al_hrs,
    output logic [DAY_W-1:0]       al_day,
    output logic                   disp_sel,
    output logic                   Buzz
);

    localparam int HW = $clog2(NH);

    mode_t mode_q, mode_d;
    logic  match;

    always_ff @(posedge Pulse) begin
        if (Reset) begin
            mode_q <= RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Timeset wins a tie from RUN; in a set mode the other request is ignored.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            RUN: begin
                if (Timeset)       mode_d = SET_TIME;
                else if (Alarmset) mode_d = SET_ALARM;
            end
            SET_TIME:  if (!Timeset)  mode_d = RUN;
            SET_ALARM: if (!Alarmset) mode_d = RUN;
            default:   mode_d = RUN;
        endcase
    end

    // The counters update on the same edge, so the enables look at the current time.
    always_comb begin
        t_sec_inc = 1'b0;
        t_min_inc = 1'b0;
        t_hrs_inc = 1'b0;
        t_day_inc = 1'b0;
        if (!Reset) begin
            case (mode_q)
                RUN: begin
                    t_sec_inc = 1'b1;
                    t_min_inc = (cur_sec == SEC_W'(NS - 1));
                    t_hrs_inc = t_min_inc && (cur_min == MIN_W'(NM - 1));
                    t_day_inc = t_hrs_inc && (cur_hrs == HW'(NH - 1));
                end
                SET_TIME: begin
                    t_min_inc = Minadv;
                    t_hrs_inc = Hrsadv;
                    t_day_inc = Dayadv;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Pulse) begin
        if (Reset) begin
            al_min <= '0;
            al_hrs <= '0;
            al_day <= '0;
        end else if (mode_q == SET_ALARM) begin
            if (Minadv) al_min <= MIN_W'(wrap_next(32'(al_min), NM));
            if (Hrsadv) al_hrs <= HW'(wrap_next(32'(al_hrs), NH));
            if (Dayadv) al_day <= DAY_W'(wrap_next(32'(al_day), ND));
        end
    end

    assign disp_sel = (mode_q == SET_ALARM);

    assign match = (mode_q == RUN) && (cur_day == al_day) && (cur_hrs == al_hrs) &&
                   (cur_min == al_min) && (cur_sec == '0);

    alarm_buzz_fsm #(
        .RING_SEC (RING_SEC),
        .SNZ_SEC  (SNZ_SEC)
    ) u_buzz (
        .clk      (Pulse),
        .reset    (Reset),
        .match    (match),
        .alarm_on (Alarmon),
        .snooze   (Snooze),
        .in_run   (mode_q == RUN),
        .buzz     (Buzz)
    );

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// tb/tb_alarm_set_ctrl.sv - self-checking bench for alarm_set_ctrl with a time-keeping model
module tb_alarm_set_ctrl;

    localparam int NS = 60, NH = 24, ND = 7, RING_SEC = 60, SNZ_SEC = 300;

    logic Pulse = 1'b0;
    logic Reset, Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon, Snooze;
    logic [5:0] cur_sec, cur_min, al_min;
    logic [4:0] cur_hrs, al_hrs;
    logic [2:0] cur_day, al_day;
    logic t_sec_inc, t_min_inc, t_hrs_inc, t_day_inc, disp_sel, Buzz;

    int n_cmp = 0, n_bad = 0;

    // Model state: mode 0=run 1=set time 2=set alarm; ring/snooze as cycles remaining.
    int m_mode = 0, m_al_min = 0, m_al_hrs = 0, m_al_day = 0, m_ring = 0, m_snz = 0;
    int t_sec = 0, t_min = 0, t_hrs = 0, t_day = 0;
    int n_sec = 0, n_min = 0, n_hrs = 0, n_day = 0, n_buzz = 0;

    assign cur_sec = 6'(t_sec);
    assign cur_min = 6'(t_min);
    assign cur_hrs = 5'(t_hrs);
    assign cur_day = 3'(t_day);

    always #5 Pulse = ~Pulse;

    alarm_set_ctrl #(.NS(NS), .NH(NH), .ND(ND), .RING_SEC(RING_SEC), .SNZ_SEC(SNZ_SEC)) dut (
        .Pulse(Pulse), .Reset(Reset), .Timeset(Timeset), .Alarmset(Alarmset),
        .Minadv(Minadv), .Hrsadv(Hrsadv), .Dayadv(Dayadv), .Alarmon(Alarmon), .Snooze(Snooze),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hrs(cur_hrs), .cur_day(cur_day),
        .t_sec_inc(t_sec_inc), .t_min_inc(t_min_inc), .t_hrs_inc(t_hrs_inc), .t_day_inc(t_day_inc),
        .al_min(al_min), .al_hrs(al_hrs), .al_day(al_day), .disp_sel(disp_sel), .Buzz(Buzz)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: compare at the falling edge, then advance the model just after the rising edge.
    initial begin
        int e_sec, e_min, e_hrs, e_day;
        int x_mode, x_min, x_hrs, x_day, x_ring, x_snz;
        bit m_match;
        forever begin
            @(negedge Pulse);
            e_sec = 0; e_min = 0; e_hrs = 0; e_day = 0;
            if (!Reset && m_mode == 0) begin
                e_sec = 1;
                e_min = (t_sec == NS - 1);
                e_hrs = e_min && (t_min == 59);
                e_day = e_hrs && (t_hrs == NH - 1);
            end else if (!Reset && m_mode == 1) begin
                e_min = Minadv; e_hrs = Hrsadv; e_day = Dayadv;
            end
            check("t_sec_inc", t_sec_inc, e_sec);
            check("t_min_inc", t_min_inc, e_min);
            check("t_hrs_inc", t_hrs_inc, e_hrs);
            check("t_day_inc", t_day_inc, e_day);
            check("al_min", al_min, m_al_min);
            check("al_hrs", al_hrs, m_al_hrs);
            check("al_day", al_day, m_al_day);
            check("disp_sel", disp_sel, int'(m_mode == 2));
            check("Buzz", Buzz, int'(m_ring > 0));
            n_sec += t_sec_inc; n_min += t_min_inc; n_hrs += t_hrs_inc; n_day += t_day_inc;
            n_buzz += Buzz;

            m_match = (m_mode == 0) && t_day == m_al_day && t_hrs == m_al_hrs &&
                      t_min == m_al_min && t_sec == 0;
            x_mode = m_mode; x_min = m_al_min; x_hrs = m_al_hrs; x_day = m_al_day;
            x_ring = m_ring; x_snz = m_snz;
            if (Reset) begin
                x_mode = 0; x_min = 0; x_hrs = 0; x_day = 0; x_ring = 0; x_snz = 0;
            end else begin
                if (m_mode == 2) begin
                    x_min = (m_al_min + Minadv) % 60;
                    x_hrs = (m_al_hrs + Hrsadv) % NH;
                    x_day = (m_al_day + Dayadv) % ND;
                end
                if (!Alarmon || m_mode != 0) begin
                    x_ring = 0; x_snz = 0;
                end else if (m_snz > 0) begin
                    x_snz = m_snz - 1;
                    if (m_snz == 1) x_ring = RING_SEC;
                end else if (m_ring > 0) begin
`ifdef SNOOZE_EN
                    if (Snooze) begin x_ring = 0; x_snz = SNZ_SEC; end
                    else x_ring = m_ring - 1;
`else
                    x_ring = m_ring - 1;
`endif
                end else if (m_match) begin
                    x_ring = RING_SEC;
                end
                if (m_mode == 0)      x_mode = Timeset ? 1 : (Alarmset ? 2 : 0);
                else if (m_mode == 1) x_mode = Timeset ? 1 : 0;
                else                  x_mode = Alarmset ? 2 : 0;
            end
            @(posedge Pulse);
            #1;
            m_mode = x_mode; m_al_min = x_min; m_al_hrs = x_hrs; m_al_day = x_day;
            m_ring = x_ring; m_snz = x_snz;
            t_sec = (t_sec + e_sec) % NS;
            t_min = (t_min + e_min) % 60;
            t_hrs = (t_hrs + e_hrs) % NH;
            t_day = (t_day + e_day) % ND;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Pulse);
            #2;
        end
    endtask

    task automatic clear_tallies();
        n_sec = 0; n_min = 0; n_hrs = 0; n_day = 0; n_buzz = 0;
    endtask

    task automatic set_time(input int d, input int h, input int m, input int s);
        t_day = d; t_hrs = h; t_min = m; t_sec = s;
    endtask

    initial begin
        Reset = 1; Timeset = 0; Alarmset = 0; Minadv = 0; Hrsadv = 0; Dayadv = 0;
        Alarmon = 0; Snooze = 0;
        step(2);
        check("reset_buzz", Buzz, 0);
        check("reset_disp", disp_sel, 0);
        check("reset_inc", t_sec_inc, 0);
        Reset = 0;
        clear_tallies();
        step(5);
        check("idle_sec_pulses", n_sec, 5);
        check("idle_al_hrs", al_hrs, 0);

        // Set current time: 59 minute advances, then 7 hour advances.
        Timeset = 1;
        step(1);
        clear_tallies();
        Minadv = 1; step(59); Minadv = 0;
        Hrsadv = 1; step(7);  Hrsadv = 0;
        check("set_min_pulses", n_min, 59);
        check("set_hrs_pulses", n_hrs, 7);
        check("set_sec_pulses", n_sec, 0);
        check("set_time_min", cur_min, 59);
        check("set_time_hrs", cur_hrs, 7);
        check("set_time_day", cur_day, 0);
        Timeset = 0;
        step(2);

        // Set alarm to 6/08:02; no counter enables meanwhile.
        Alarmset = 1;
        step(1);
        clear_tallies();
        Hrsadv = 1; step(8); Hrsadv = 0;
        Minadv = 1; step(2); Minadv = 0;
        Dayadv = 1; step(6); Dayadv = 0;
        check("al_day_6", al_day, 6);
        check("al_hrs_8", al_hrs, 8);
        check("al_min_2", al_min, 2);
        check("al_disp", disp_sel, 1);
        check("al_no_inc", n_sec + n_min + n_hrs + n_day, 0);
        Alarmset = 0;
        step(2);

        // Full carry chain at end of week day 0.
        set_time(0, 23, 59, 59);
        #1;
        check("carry_sec", t_sec_inc, 1);
        check("carry_min", t_min_inc, 1);
        check("carry_hrs", t_hrs_inc, 1);
        check("carry_day", t_day_inc, 1);
        step(1);

        // Alarm to 0/08:00 (min 2+58 wraps, day 6+1 wraps), then ring.
        Alarmset = 1;
        step(1);
        Minadv = 1; step(58); Minadv = 0;
        Dayadv = 1; step(1);  Dayadv = 0;
        Alarmset = 0;
        step(2);
        check("al_wrap_min", al_min, 0);
        check("al_wrap_day", al_day, 0);
        set_time(0, 7, 59, 55);
        Alarmon = 1;
        clear_tallies();
        step(80);
        check("ring_len", n_buzz, 60);

        set_time(0, 7, 59, 58);
        clear_tallies();
        step(12);
        Alarmon = 0;
        step(1);
        check("alarmoff_buzz", Buzz, 0);
        step(10);
        check("alarmoff_len", n_buzz, 10);

        // Tie of both set requests goes to SET_TIME; Alarmset then waits for RUN.
        Timeset = 1; Alarmset = 1;
        step(1);
        check("tie_disp", disp_sel, 0);
        check("tie_sec", t_sec_inc, 0);
        Timeset = 0;
        step(2);
        check("tie_then_alarm", disp_sel, 1);
        Alarmset = 0;
        step(2);

        // Reset in the middle of a ring and a set request.
        Alarmon = 1;
        set_time(0, 7, 59, 58);
        step(6);
        check("pre_reset_buzz", Buzz, 1);
        Timeset = 1; Reset = 1;
        step(2);
        check("midring_reset_buzz", Buzz, 0);
        check("midring_reset_al", al_hrs, 0);
        check("midring_reset_disp", disp_sel, 0);
        Reset = 0; Timeset = 0;
        step(2);

`ifdef SNOOZE_EN
        // Alarm is now 0/00:00; reach it via the week wrap, then snooze.
        set_time(6, 23, 59, 58);
        step(4);
        check("snz_pre", Buzz, 1);
        Snooze = 1;
        step(1);
        Snooze = 0;
        clear_tallies();
        step(300);
        check("snz_quiet", n_buzz, 0);
        check("snz_rering", Buzz, 1);
`endif

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
